// File: rtl/axi_mem_pkg.sv
// Shared constants and state types for the on-chip AXI memory responder.
// Default widths match the FPGA-side memory AXI master.
package axi_mem_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 64;
  localparam int ID_W_DEF      = 6;
  localparam int MEM_BYTES_DEF = 65536;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  // A write burst is clean only when w_last and the final counted beat coincide.
  function automatic logic [1:0] burst_resp(input logic last_flag, input logic at_len);
    return (last_flag && at_len) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, enabled read port with a
// registered, read-first output. Storage is split into one array per byte lane.
module axi_mem_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int AW     = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB = DATA_W / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clock) begin
        if (we && be[gi]) begin
          lane_mem[waddr] <= wdata[gi*8 +: 8];
        end
      end

      // Output register is the only part cleared by reset; contents persist.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rd_q <= '0;
        end else if (re) begin
          rd_q <= lane_mem[raddr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave that terminates the memory AXI master in on-chip RAM.
// Independent read and write FSMs, one INCR burst outstanding on each.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [7:0]          aw_len,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [7:0]          ar_len,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [ID_W-1:0]     r_id,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_last
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_BYTES) - LSB;
  localparam int DEPTH  = MEM_BYTES / STRB_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // ---------------- write channel ----------------
  w_state_t         w_state_reg, w_state_next;
  logic [7:0]       w_len_reg, w_cnt_reg;
  logic [IDX_W-1:0] w_idx_reg;
  logic [ID_W-1:0]  b_id_reg;
  logic [1:0]       b_resp_reg;
  logic             aw_fire, w_fire, w_at_len, w_final;

  assign w_at_len = (w_cnt_reg == w_len_reg);
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;
  assign w_final  = w_fire && (w_last || w_at_len);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state_reg <= W_IDLE;
    end else begin
      w_state_reg <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (aw_valid) w_state_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_valid && (w_last || w_at_len)) w_state_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_len_reg  <= '0;
      w_cnt_reg  <= '0;
      w_idx_reg  <= '0;
      b_id_reg   <= '0;
      b_resp_reg <= RESP_OKAY;
    end else if (aw_fire) begin
      w_len_reg <= aw_len;
      w_cnt_reg <= '0;
      w_idx_reg <= aw_addr[LSB +: IDX_W];
      b_id_reg  <= aw_id;
    end else if (w_fire) begin
      w_cnt_reg <= w_cnt_reg + 8'd1;
      w_idx_reg <= w_idx_reg + IDX_ONE;
      if (w_final) b_resp_reg <= burst_resp(w_last, w_at_len);
    end
  end

  assign b_id   = b_id_reg;
  assign b_resp = b_resp_reg;

  // ---------------- read channel ----------------
  r_state_t         r_state_reg, r_state_next;
  logic [7:0]       r_len_reg, r_cnt_reg;
  logic [IDX_W-1:0] r_idx_reg;
  logic [ID_W-1:0]  r_id_reg;
  logic             r_issue_reg, r_valid_reg, r_last_reg;
  logic             ar_fire, rd_en;

  assign ar_fire = ar_valid && ar_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
    end
  end

  // RAM enable is gated by the output slot so a stalled beat never moves.
  always_comb begin
    r_state_next = r_state_reg;
    ar_ready     = 1'b0;
    rd_en        = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) r_state_next = R_BURST;
      end
      R_BURST: begin
        rd_en = r_issue_reg && (!r_valid_reg || r_ready);
        if (r_valid_reg && r_ready && r_last_reg) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_idx_reg   <= '0;
      r_id_reg    <= '0;
      r_issue_reg <= 1'b0;
      r_valid_reg <= 1'b0;
      r_last_reg  <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_len_reg   <= ar_len;
        r_cnt_reg   <= '0;
        r_idx_reg   <= ar_addr[LSB +: IDX_W];
        r_id_reg    <= ar_id;
        r_issue_reg <= 1'b1;
      end
      if (rd_en) begin
        r_cnt_reg   <= r_cnt_reg + 8'd1;
        r_idx_reg   <= r_idx_reg + IDX_ONE;
        r_valid_reg <= 1'b1;
        r_last_reg  <= (r_cnt_reg == r_len_reg);
        if (r_cnt_reg == r_len_reg) r_issue_reg <= 1'b0;
      end else if (r_ready) begin
        r_valid_reg <= 1'b0;
        r_last_reg  <= 1'b0;
      end
    end
  end

  assign r_valid = r_valid_reg;
  assign r_last  = r_last_reg;
  assign r_id    = r_id_reg;
  assign r_resp  = RESP_OKAY;

  axi_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (w_fire),
    .waddr   (w_idx_reg),
    .be      (w_strb),
    .wdata   (w_data),
    .re      (rd_en),
    .raddr   (r_idx_reg),
    .rdata   (r_data)
  );

  // Low offset bits and bits above the RAM size are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr, ar_addr};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected B responses and R beats are
// queued as stimulus is driven and checked when the DUT presents them.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic [31:0] aw_addr, ar_addr;
  logic [5:0]  aw_id, ar_id, b_id, r_id;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [63:0] w_data, r_data;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [1:0]  b_resp, r_resp;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clock(clk), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
  );

  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re_cur;
  bexp_t be_cur;

  logic [63:0] mem_model [8192];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ar_cyc = 0, ar_seq = 0, seen_seq = 0, w_end_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- output monitor ----------------
  logic        prev_stall = 1'b0;
  logic        prev_lastfire = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall    <= 1'b0;
      prev_lastfire <= 1'b0;
    end else begin
      if (prev_lastfire) check("ar_ready_after_last", ar_ready, 1);
      if (prev_stall) begin
        check("r_valid_hold", r_valid, 1);
        check("r_data_hold", r_data, prev_data);
        check("r_last_hold", r_last, prev_last);
      end
      if (r_valid && seen_seq != ar_seq) begin
        check("r_latency", cyc - ar_cyc, 2);
        seen_seq <= ar_seq;
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 1, 0);
        end else begin
          re_cur = rq.pop_front();
          check("r_data", r_data, re_cur.data);
          check("r_id", r_id, re_cur.id);
          check("r_last", r_last, re_cur.last);
          check("r_resp", r_resp, RESP_OKAY);
          $display("RD  id=%0d data=%h last=%0b", r_id, r_data, r_last);
        end
      end
      prev_lastfire <= r_valid && r_ready && r_last;
      prev_stall    <= r_valid && !r_ready;
      prev_data     <= r_data;
      prev_last     <= r_last;

      if (b_valid && b_ready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 1, 0);
        end else begin
          be_cur = bq.pop_front();
          check("b_id", b_id, be_cur.id);
          check("b_resp", b_resp, be_cur.resp);
          check("b_latency", cyc - w_end_cyc, 1);
          $display("WR  id=%0d resp=%0d", b_id, b_resp);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic write_burst(input logic [31:0] addr, input logic [5:0] id,
                             input int len, input int last_at);
    int n;
    int nbeats;
    int idx;
    nbeats = (last_at < len) ? last_at + 1 : len + 1;
    bq.push_back('{id, (last_at == len) ? RESP_OKAY : RESP_SLVERR});
    @(posedge clk);
    #1;
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = 8'(len);
    n = 0;
    do begin @(negedge clk); n++; end while (!aw_ready && n < 50);
    check("aw_handshake", aw_ready, 1);
    @(posedge clk);
    #1 aw_valid = 1'b0;
    @(negedge clk);
    check("aw_ready_busy", aw_ready, 0);
    check("w_ready_after_aw", w_ready, 1);
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1; w_data = wdat[i]; w_strb = wstb[i]; w_last = (i == last_at);
      n = 0;
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      w_end_cyc = cyc;
      idx = ((addr >> 3) + i) % 8192;
      for (int b = 0; b < 8; b++)
        if (wstb[i][b]) mem_model[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    n = 0;
    while (bq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("b_drained", bq.size(), 0);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [5:0] id, input int len,
                            input bit toggle, input int abort_after);
    int n;
    for (int k = 0; k <= len; k++)
      rq.push_back('{id, mem_model[((addr >> 3) + k) % 8192], (k == len)});
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = 8'(len);
    n = 0;
    do begin @(negedge clk); n++; end while (!ar_ready && n < 50);
    check("ar_handshake", ar_ready, 1);
    ar_cyc = cyc;
    ar_seq++;
    @(posedge clk);
    #1 ar_valid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 200 && !(abort_after > 0 && n == abort_after)) begin
      @(posedge clk);
      #1;
      if (toggle) r_ready = !r_ready;
      n++;
    end
    if (abort_after > 0) begin
      reset_n = 1'b0;
      rq.delete();
      repeat (2) @(negedge clk);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_last", r_last, 0);
      check("rst_b_valid", b_valid, 0);
      @(posedge clk);
      #1 reset_n = 1'b1; r_ready = 1'b1;
      @(negedge clk);
      check("post_rst_ar_ready", ar_ready, 1);
      check("post_rst_aw_ready", aw_ready, 1);
      check("post_rst_r_valid", r_valid, 0);
    end else begin
      check("r_drained", rq.size(), 0);
      r_ready = 1'b1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
    b_ready = 1; r_ready = 1;
    for (int i = 0; i < 256; i++) begin wdat[i] = '0; wstb[i] = 8'hFF; end

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_aw_ready", aw_ready, 1);
    check("reset_ar_ready", ar_ready, 1);
    check("reset_w_ready", w_ready, 0);
    check("reset_b_valid", b_valid, 0);
    check("reset_r_valid", r_valid, 0);
    check("reset_r_last", r_last, 0);
    check("reset_b_id", b_id, 0);
    check("reset_b_resp", b_resp, 0);
    check("reset_r_id", r_id, 0);
    check("reset_r_data", r_data, 0);
    check("reset_r_resp", r_resp, 0);

    // single beat write and readback
    wdat[0] = 64'hDEADBEEF_CAFEF00D;
    write_burst(32'h10, 6'd5, 0, 0);
    read_burst(32'h10, 6'd5, 0, 0, 0);

    // four-beat burst, back-to-back reads
    for (int i = 0; i < 4; i++) wdat[i] = 64'(i + 1);
    write_burst(32'h100, 6'd1, 3, 3);
    read_burst(32'h100, 6'd2, 3, 0, 0);

    // partial strobe over a preloaded word
    wdat[0] = '1;
    write_burst(32'h0, 6'd3, 0, 0);
    wdat[0] = '0; wstb[0] = 8'h0F;
    write_burst(32'h0, 6'd4, 0, 0);
    wstb[0] = 8'hFF;
    read_burst(32'h0, 6'd4, 0, 0, 0);

    // wrap past top of RAM
    wdat[0] = 64'hAAAA_0000_1111_2222; wdat[1] = 64'hBBBB_3333_4444_5555;
    write_burst(32'hFFF8, 6'd7, 1, 1);
    read_burst(32'hFFF8, 6'd8, 0, 0, 0);
    read_burst(32'h0, 6'd9, 0, 0, 0);
    read_burst(32'hFFF8, 6'd10, 1, 0, 0);

    // early w_last, then a clean burst, then missing w_last
    wdat[0] = 64'h1234; wdat[1] = 64'h5678;
    write_burst(32'h300, 6'd11, 3, 1);
    wdat[0] = 64'h9ABC; wdat[1] = 64'hDEF0;
    write_burst(32'h400, 6'd12, 1, 1);
    wdat[0] = 64'h0F0F; wdat[1] = 64'hF0F0;
    write_burst(32'h500, 6'd13, 1, 99);
    read_burst(32'h300, 6'd14, 1, 0, 0);
    read_burst(32'h500, 6'd15, 1, 0, 0);

    // backpressure on an 8-beat read
    for (int i = 0; i < 8; i++) wdat[i] = {$urandom(), $urandom()};
    write_burst(32'h200, 6'd20, 7, 7);
    read_burst(32'h200, 6'd21, 7, 1, 0);

    // reset in the middle of a read burst; RAM must survive
    read_burst(32'h200, 6'd22, 7, 1, 6);
    read_burst(32'h100, 6'd23, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
